wb_regfile: RTL

Writeback-stage consumer of the MEM/WB pipeline register. It selects the writeback value (load data or ALU result), commits it into a 32 x XLEN integer register file, and serves the two ID-stage read ports. x0 is hardwired to zero. A committed-write counter is kept for performance and debug. The block sits between the MEM/WB register and the ID/EX register, and drives the writeback value to the forwarding unit.

---
 rtl/wb_regfile.sv | 70 +++++++
 1 files changed

// File: rtl/wb_regfile.sv
// Writeback stage: selects load/ALU result, commits it into a 32 x XLEN register
// file with hardwired x0, serves two async read ports and counts committed writes.
// Optional same-cycle write-to-read bypass is enabled by defining REGFILE_BYPASS_EN.
module wb_regfile #(
  parameter int unsigned XLEN  = 64,
  parameter int unsigned CNT_W = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             MEM_WB_RegWrite,
  input  logic             MEM_WB_MemToReg,
  input  logic [4:0]       MEM_WB_RD,
  input  logic [XLEN-1:0]  MEM_WB_ReadData,
  input  logic [XLEN-1:0]  MEM_WB_ALU_Result,
  input  logic [4:0]       rs1,
  input  logic [4:0]       rs2,
  output logic [XLEN-1:0]  ReadData1,
  output logic [XLEN-1:0]  ReadData2,
  output logic [XLEN-1:0]  WB_Data,
  output logic             WB_Commit,
  output logic [CNT_W-1:0] wb_count
);

  localparam int unsigned NREGS = 32;

  logic [XLEN-1:0] regs [1:NREGS-1];

  // Writeback select and commit qualification; reset low suppresses the commit.
  always_comb begin
    WB_Data   = MEM_WB_MemToReg ? MEM_WB_ReadData : MEM_WB_ALU_Result;
    WB_Commit = MEM_WB_RegWrite & (MEM_WB_RD != 5'd0) & reset;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 1; i < NREGS; i++) regs[i] <= '0;
    end else if (WB_Commit) begin
      regs[MEM_WB_RD] <= WB_Data;
    end
  end

  // Committed-write counter, wraps silently.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wb_count <= '0;
    end else if (WB_Commit) begin
      wb_count <= wb_count + CNT_W'(1);
    end
  end

  function automatic logic [XLEN-1:0] read_port(input logic [4:0] idx);
    logic [XLEN-1:0] val;
    val = '0;
    if (idx != 5'd0) begin
`ifdef REGFILE_BYPASS_EN
      if (WB_Commit && (MEM_WB_RD == idx)) val = WB_Data;
      else                                 val = regs[idx];
`else
      val = regs[idx];
`endif
    end
    return val;
  endfunction

  always_comb begin
    ReadData1 = read_port(rs1);
    ReadData2 = read_port(rs2);
  end

endmodule
